// File: rtl/hnext_tile_sched.sv
// hnext_tile_sched: tile sequencer for the h_next FP16 adder array.
// Sweeps an (NH, NP, NN) tile grid, launches one tile per accepted operand beat,
// follows each tile through the fixed-latency adder with a tag pipe, and hands
// the write-back address of each result out in launch order. A credit count
// (tiles in flight plus queued tags) keeps the external result FIFO from overflowing.
// Optional build macro: HNEXT_SCHED_CHECK_EN enables a sticky err_o that flags
// any cycle where the adder's valid output disagrees with the tag pipe.
module hnext_tile_sched #(
    parameter int A_LAT      = 11,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cfg_nh_i,
    input  logic [CNT_W-1:0]  cfg_np_i,
    input  logic [CNT_W-1:0]  cfg_nn_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              add_valid_o,
    input  logic              add_valid_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              err_o
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched grid size and sweep position
    logic [CNT_W-1:0]  nh_q, np_q, nn_q;
    logic [CNT_W-1:0]  nh_d, np_d, nn_d;
    logic [CNT_W-1:0]  h_q, p_q, n_q;
    logic [CNT_W-1:0]  h_d, p_d, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Credit count and tag FIFO state
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] tag_mem [FIFO_DEPTH];

    // Tag pipe: stage k holds the tile launched k cycles ago
    logic [A_LAT:1]    pipe_v_q;
    logic [ADDR_W-1:0] pipe_addr_q [1:A_LAT];

    logic launch;
    logic pop;
    logic push;
    logic last_tile;
    logic cfg_zero;

    assign in_ready_o  = (state_q == S_RUN) && (occ_q < OCC_W'(FIFO_DEPTH));
    assign launch      = in_valid_i && in_ready_o;
    assign add_valid_o = launch;
    assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);

    assign push       = pipe_v_q[A_LAT];
    assign wr_valid_o = (cnt_q != '0);
    assign pop        = wr_valid_o && wr_ready_i;
    // Head is only meaningful while a tag is queued; report 0 otherwise
    assign wr_addr_o  = wr_valid_o ? tag_mem[rd_ptr_q] : '0;

    assign last_tile = (h_q == nh_q - 1'b1) && (p_q == np_q - 1'b1) && (n_q == nn_q - 1'b1);
    assign cfg_zero  = (cfg_nh_i == '0) || (cfg_np_i == '0) || (cfg_nn_i == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and done pulse; drain ends on the cycle the last credit returns
    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = cfg_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (launch && last_tile) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep counters: n fastest, then p, then h; addr tracks (h*NP+p)*NN+n linearly
    always_comb begin
        nh_d   = nh_q;
        np_d   = np_q;
        nn_d   = nn_q;
        h_d    = h_q;
        p_d    = p_q;
        n_d    = n_q;
        addr_d = addr_q;
        if (state_q == S_IDLE && start_i) begin
            nh_d   = cfg_nh_i;
            np_d   = cfg_np_i;
            nn_d   = cfg_nn_i;
            h_d    = '0;
            p_d    = '0;
            n_d    = '0;
            addr_d = '0;
        end else if (launch) begin
            addr_d = addr_q + 1'b1;
            if (n_q == nn_q - 1'b1) begin
                n_d = '0;
                if (p_q == np_q - 1'b1) begin
                    p_d = '0;
                    h_d = h_q + 1'b1;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end else begin
                n_d = n_q + 1'b1;
            end
        end
    end

    // Counter and config registers
    always_ff @(posedge clk) begin
        if (rst) begin
            nh_q   <= '0;
            np_q   <= '0;
            nn_q   <= '0;
            h_q    <= '0;
            p_q    <= '0;
            n_q    <= '0;
            addr_q <= '0;
        end else begin
            nh_q   <= nh_d;
            np_q   <= np_d;
            nn_q   <= nn_d;
            h_q    <= h_d;
            p_q    <= p_d;
            n_q    <= n_d;
            addr_q <= addr_d;
        end
    end

    // Tag pipe valid bits shift every cycle; the pipe never stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_q <= '0;
        end else begin
            pipe_v_q <= {pipe_v_q[A_LAT-1:1], launch};
        end
    end

    // Tag pipe address stages, one register per adder stage
    generate
        for (genvar gi = 1; gi <= A_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_addr_q[gi] <= '0;
                end else if (gi == 1) begin
                    pipe_addr_q[gi] <= addr_q;
                end else begin
                    pipe_addr_q[gi] <= pipe_addr_q[(gi > 1) ? gi - 1 : 1];
                end
            end
        end
    endgenerate

    // Credit: a pop frees its slot only from the next cycle on
    always_comb begin
        occ_d = occ_q;
        case ({launch, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Tag FIFO occupancy; push and pop together leave it unchanged
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit count, FIFO count and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    // Tag FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= pipe_addr_q[A_LAT];
        end
    end

`ifdef HNEXT_SCHED_CHECK_EN
    logic err_q;

    // Sticky flag: adder valid must line up with the last tag-pipe stage
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (add_valid_i != pipe_v_q[A_LAT]) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_add_valid;

    assign unused_add_valid = add_valid_i;
    assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_hnext_tile_sched.sv
// Self-checking bench for hnext_tile_sched: randomized operand/consumer
// handshakes, a queue of expected write-back addresses built from the grid
// rules, and a monitor that pops and compares on every consumed result.
module tb_hnext_tile_sched;

    localparam int A_LAT = 11;
    localparam int FD    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  cfg_nh_i = '0;
    logic [7:0]  cfg_np_i = '0;
    logic [7:0]  cfg_nn_i = '0;
    logic        busy_o, done_o;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o, add_valid_o;
    logic        add_valid_i;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b0;
    logic [15:0] wr_addr_o;
    logic        err_o;

    hnext_tile_sched #(.A_LAT(A_LAT), .FIFO_DEPTH(FD), .CNT_W(8), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .cfg_nh_i   (cfg_nh_i),
        .cfg_np_i   (cfg_np_i),
        .cfg_nn_i   (cfg_nn_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .add_valid_o(add_valid_o),
        .add_valid_i(add_valid_i),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .wr_addr_o  (wr_addr_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder: valid comes back A_LAT cycles after launch
    logic [A_LAT-1:0] adl = '0;
    int kill_cyc = -1;
    always @(posedge clk) begin
        if (rst) adl <= '0;
        else     adl <= {adl[A_LAT-2:0], add_valid_o};
    end
    assign add_valid_i = adl[A_LAT-1] && (cyc != kill_cyc);

    // Handshake drivers: 0 = low, 1 = high, 2 = coin flip, 3 = mostly high
    int iv_mode = 0;
    int wr_mode = 0;
    function automatic logic pick(int m);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction
    always @(posedge clk) begin
        #1;
        in_valid_i = pick(iv_mode);
        wr_ready_i = pick(wr_mode);
    end

    int n_vec  = 0;
    int n_miss = 0;
    task automatic check(string nm, longint act, longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard state shared with the monitor
    logic [15:0] exp_q[$];
    int launch_log[$];
    int wr_log[$];
    int n_launch    = 0;
    int outstanding = 0;

    // Monitor: credit rule on every launch, address order on every consumed result
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (add_valid_o) begin
                check("credit", (outstanding < FD) ? 1 : 0, 1);
                outstanding++;
                n_launch++;
                launch_log.push_back(cyc);
            end
            if (wr_valid_o && wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", wr_addr_o, -1);
                end else begin
                    check("wr_addr", wr_addr_o, exp_q.pop_front());
                end
                outstanding--;
                wr_log.push_back(cyc);
            end
        end
    end

    task automatic check_quiet(string tag);
        check({tag, "_busy"},     busy_o, 0);
        check({tag, "_done"},     done_o, 0);
        check({tag, "_in_ready"}, in_ready_o, 0);
        check({tag, "_add_vld"},  add_valid_o, 0);
        check({tag, "_wr_vld"},   wr_valid_o, 0);
        check({tag, "_wr_addr"},  wr_addr_o, 0);
        check({tag, "_err"},      err_o, 0);
    endtask

    // One sweep: queue expected addresses, start, run until done_o (bounded).
    // stall > 0: consumer held off for that many cycles, then credit state checked.
    task automatic sweep(int nh, int np, int nn, int stall, int kill_off,
                         output int c0, output int dcyc);
        int busy_hi;
        int busy_lo;
        bit seen;
        int total;
        total = nh * np * nn;
        for (int h = 0; h < nh; h++)
            for (int p = 0; p < np; p++)
                for (int n = 0; n < nn; n++)
                    exp_q.push_back(16'((h * np + p) * nn + n));
        n_launch = 0;
        launch_log.delete();
        wr_log.delete();
        @(posedge clk); #1;
        cfg_nh_i = 8'(nh); cfg_np_i = 8'(np); cfg_nn_i = 8'(nn);
        start_i = 1'b1;
        c0 = cyc;
        if (kill_off > 0) kill_cyc = c0 + kill_off;
        @(posedge clk); #1;
        start_i = 1'b0;
        busy_hi = 0; busy_lo = 0; seen = 0; dcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1;
                dcyc = cyc;
                break;
            end
            if (busy_o) busy_hi++; else busy_lo++;
            if (stall > 0 && i == stall) begin
                check("stall_launches", n_launch, FD);
                check("stall_in_ready", in_ready_o, 0);
                check("stall_wr_valid", wr_valid_o, 1);
                wr_mode = 1;
            end
        end
        check("done_seen", seen, 1);
        check("launches", n_launch, total);
        if (total == 0) check("busy_hi_cycles", busy_hi, 0);
        else            check("busy_lo_cycles", busy_lo, 0);
        check("exp_left", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", done_o, 0);
        kill_cyc = -1;
        exp_q.delete();
    endtask

    int c0, dc;
    bit exp_err;

    initial begin
`ifdef HNEXT_SCHED_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed latency sweep, tile 2's adder valid suppressed
        iv_mode = 1; wr_mode = 1;
        sweep(1, 1, 4, 0, A_LAT + 3, c0, dc);
        for (int i = 0; i < 4; i++) begin
            check("launch_cycle", (i < launch_log.size()) ? launch_log[i] - c0 : -1, 1 + i);
            check("wr_cycle",     (i < wr_log.size())     ? wr_log[i] - c0     : -1, A_LAT + 2 + i);
        end
        check("done_cycle", dc - c0, A_LAT + 6);
        check("err_after_kill", err_o, exp_err);

        // Streamed multi-dimensional grid
        sweep(2, 3, 2, 0, 0, c0, dc);
        check("err_sticky", err_o, exp_err);

        // Consumer stalled: credits cap launches at FIFO depth, then all drain
        iv_mode = 1; wr_mode = 0;
        sweep(1, 1, 40, 60, 0, c0, dc);

        // Zero-sized grid finishes immediately with no launches
        iv_mode = 1; wr_mode = 1;
        sweep(0, 5, 5, 0, 0, c0, dc);
        check("zero_done_cycle", dc - c0, 1);

        // Reset part-way through a sweep
        @(posedge clk); #1;
        cfg_nh_i = 8'd1; cfg_np_i = 8'd1; cfg_nn_i = 8'd8;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        sweep(1, 1, 8, 0, 0, c0, dc);

        // Randomized grids and handshakes
        for (int k = 0; k < 8; k++) begin
            iv_mode = $urandom_range(1, 3);
            wr_mode = $urandom_range(1, 3);
            sweep($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 5), 0, 0, c0, dc);
        end
        check("err_final", err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
